// File: rtl/instruction_issuer.sv
// -----------------------------------------------------------------------------
// instruction_issuer
//
// Buffers opcodes from a producer in a small FIFO and issues them one per
// cycle to the instruction decoder. A memory-read opcode (3'b100) is always
// followed by a one-cycle bubble. Illegal opcodes are dropped and recorded in
// a sticky error flag.
//
// Handshake: an opcode is accepted on a rising edge where op_valid and
// op_ready are both high. op_ready is combinational and depends only on the
// FIFO occupancy (high unless full), never on op_valid. The producer keeps
// op_in stable while op_valid is high and op_ready is low.
//
// Ports
//   clk          in   1  clock, rising edge active
//   rst          in   1  asynchronous active-high reset
//   op_in        in   3  opcode from the producer
//   op_valid     in   1  qualifies op_in
//   op_ready     out  1  FIFO can take an entry (= !full)
//   stall        in   1  decoder-side hold request
//   op_out       out  3  registered opcode to the decoder
//   op_out_valid out  1  qualifies op_out (registered)
//   err          out  1  sticky: an illegal opcode was accepted
//   issued_cnt   out  8  number of opcodes issued, wraps at 256
//   fsm_state    out  2  current FSM state (IDLE=0, ISSUE=1, BUBBLE=2)
// -----------------------------------------------------------------------------
module instruction_issuer #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] op_in,
   input  logic       op_valid,
   output logic       op_ready,
   input  logic       stall,
   output logic [2:0] op_out,
   output logic       op_out_valid,
   output logic       err,
   output logic [7:0] issued_cnt,
   output logic [1:0] fsm_state
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [2:0] OP_NOP      = 3'b000;
   localparam logic [2:0] OP_MEM_READ = 3'b100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      BUBBLE = 2'd2
   } state_t;

   state_t        state, state_next;

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic          full, empty;
   logic          legal, accept, push, pop;
   logic [2:0]    head;

   logic [2:0]    op_out_next;
   logic          op_out_valid_next;

   // ---------------------------------------------------------------------------
   // Input side
   // ---------------------------------------------------------------------------
   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign op_ready = ~full;

   assign legal  = (op_in != OP_NOP) && (op_in < 3'b110);
   assign accept = op_valid & op_ready;
   // Illegal opcodes are consumed by the handshake but never stored.
   assign push   = accept & legal;

   assign head = mem[rd_ptr];

   // ---------------------------------------------------------------------------
   // FSM next-state / issue decision
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next        = state;
      pop               = 1'b0;
      op_out_next       = op_out;
      op_out_valid_next = op_out_valid;

      // stall freezes everything on the issue side; the defaults hold it.
      if (!stall) begin
         case (state)
            IDLE, ISSUE: begin
               if (!empty) begin
                  pop               = 1'b1;
                  op_out_next       = head;
                  op_out_valid_next = 1'b1;
                  // A memory read needs one dead cycle behind it.
                  state_next        = (head == OP_MEM_READ) ? BUBBLE : ISSUE;
               end else begin
                  op_out_next       = OP_NOP;
                  op_out_valid_next = 1'b0;
                  state_next        = IDLE;
               end
            end
            BUBBLE: begin
               op_out_next       = OP_NOP;
               op_out_valid_next = 1'b0;
               state_next        = IDLE;
            end
            default: begin
               op_out_next       = OP_NOP;
               op_out_valid_next = 1'b0;
               state_next        = IDLE;
            end
         endcase
      end
   end

   assign fsm_state = state;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         op_out       <= OP_NOP;
         op_out_valid <= 1'b0;
         issued_cnt   <= 8'd0;
      end else begin
         state        <= state_next;
         op_out       <= op_out_next;
         op_out_valid <= op_out_valid_next;
         if (pop) begin
            issued_cnt <= issued_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (accept && !legal) begin
         err <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO pointers and occupancy (DEPTH is a power of two, so the pointers
   // wrap naturally at their width)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= op_in;
      end
   end

endmodule

// File: tb/tb_instruction_issuer.sv
// -----------------------------------------------------------------------------
// tb_instruction_issuer
//
// Directed bench for instruction_issuer with DEPTH = 4. Inputs change and
// outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_issuer;

   logic       clk;
   logic       rst;
   logic [2:0] op_in;
   logic       op_valid;
   logic       op_ready;
   logic       stall;
   logic [2:0] op_out;
   logic       op_out_valid;
   logic       err;
   logic [7:0] issued_cnt;
   logic [1:0] fsm_state;

   int checks   = 0;
   int failures = 0;

   instruction_issuer #(.DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .op_in        (op_in),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .stall        (stall),
      .op_out       (op_out),
      .op_out_valid (op_out_valid),
      .err          (err),
      .issued_cnt   (issued_cnt),
      .fsm_state    (fsm_state)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Helpers
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] observed,
                        input logic [7:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic check_out(input string tag, input logic [2:0] exp_op,
                            input logic exp_valid, input logic [7:0] exp_cnt);
      check({tag, ".op_out"}, 8'(op_out), 8'(exp_op));
      check({tag, ".valid"}, 8'(op_out_valid), 8'(exp_valid));
      check({tag, ".cnt"}, issued_cnt, exp_cnt);
   endtask

   task automatic drive(input logic v, input logic [2:0] op);
      op_valid = v;
      op_in    = op;
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst      = 1'b1;
      stall    = 1'b0;
      op_valid = 1'b0;
      op_in    = 3'b000;

      // Reset values, before any clock edge.
      #1;
      check_out("reset", 3'b000, 1'b0, 8'd0);
      check("reset.ready", 8'(op_ready), 8'd1);
      check("reset.err", 8'(err), 8'd0);
      check("reset.state", 8'(fsm_state), 8'd0);

      #29;                                   // t = 30 ns
      rst = 1'b0;

      // --- Three legal opcodes back to back -----------------------------------
      drive(1'b1, 3'b001);
      tick();                                // edge 1: accept 001
      check_out("seq.e1", 3'b000, 1'b0, 8'd0);
      drive(1'b1, 3'b010);
      tick();                                // edge 2: issue 001
      check_out("seq.e2", 3'b001, 1'b1, 8'd1);
      check("seq.e2.state", 8'(fsm_state), 8'd1);
      drive(1'b1, 3'b011);
      tick();
      check_out("seq.e3", 3'b010, 1'b1, 8'd2);
      drive(1'b0, 3'b000);
      tick();
      check_out("seq.e4", 3'b011, 1'b1, 8'd3);
      tick();
      check_out("seq.idle", 3'b000, 1'b0, 8'd3);
      check("seq.idle.state", 8'(fsm_state), 8'd0);

      // --- Memory read followed by a bubble -----------------------------------
      drive(1'b1, 3'b100);
      tick();
      drive(1'b1, 3'b101);
      tick();
      check_out("mrd.issue", 3'b100, 1'b1, 8'd4);
      check("mrd.state", 8'(fsm_state), 8'd2);
      drive(1'b0, 3'b000);
      tick();
      check_out("mrd.bubble", 3'b000, 1'b0, 8'd4);
      tick();
      check_out("mrd.next", 3'b101, 1'b1, 8'd5);
      tick();
      check_out("mrd.idle", 3'b000, 1'b0, 8'd5);

      // --- Fill under stall, one extra dropped --------------------------------
      stall = 1'b1;
      drive(1'b1, 3'b011);
      tick();
      check("full.ready1", 8'(op_ready), 8'd1);
      drive(1'b1, 3'b001);
      tick();
      drive(1'b1, 3'b101);
      tick();
      drive(1'b1, 3'b010);
      tick();
      check("full.ready4", 8'(op_ready), 8'd0);
      drive(1'b1, 3'b001);                   // offered while full: ignored
      tick();
      check("full.ready5", 8'(op_ready), 8'd0);
      check_out("full.frozen", 3'b000, 1'b0, 8'd5);
      drive(1'b0, 3'b000);
      stall = 1'b0;
      tick();
      check_out("drain.1", 3'b011, 1'b1, 8'd6);
      check("drain.ready", 8'(op_ready), 8'd1);
      tick();
      check_out("drain.2", 3'b001, 1'b1, 8'd7);
      tick();
      check_out("drain.3", 3'b101, 1'b1, 8'd8);
      tick();
      check_out("drain.4", 3'b010, 1'b1, 8'd9);
      tick();
      check_out("drain.empty", 3'b000, 1'b0, 8'd9);

      // --- Stall while issuing 011 --------------------------------------------
      drive(1'b1, 3'b011);
      tick();
      drive(1'b1, 3'b010);
      tick();
      check_out("hold.issue", 3'b011, 1'b1, 8'd10);
      drive(1'b0, 3'b000);
      stall = 1'b1;
      tick();
      check_out("hold.s1", 3'b011, 1'b1, 8'd10);
      tick();
      check_out("hold.s2", 3'b011, 1'b1, 8'd10);
      stall = 1'b0;
      tick();
      check_out("hold.release", 3'b010, 1'b1, 8'd11);
      tick();
      check_out("hold.idle", 3'b000, 1'b0, 8'd11);

      // --- Illegal opcodes -----------------------------------------------------
      check("ill.err0", 8'(err), 8'd0);
      drive(1'b1, 3'b110);
      tick();
      check("ill.err1", 8'(err), 8'd1);
      drive(1'b1, 3'b000);
      tick();
      check("ill.err2", 8'(err), 8'd1);
      drive(1'b1, 3'b010);
      tick();
      check_out("ill.noissue", 3'b000, 1'b0, 8'd11);
      drive(1'b0, 3'b000);
      tick();
      check_out("ill.issue", 3'b010, 1'b1, 8'd12);
      tick();
      check_out("ill.idle", 3'b000, 1'b0, 8'd12);
      check("ill.sticky", 8'(err), 8'd1);

      // --- Asynchronous reset with entries queued -----------------------------
      drive(1'b1, 3'b001);
      tick();
      drive(1'b1, 3'b010);
      tick();                                // issue 001, push 010
      stall = 1'b1;
      drive(1'b1, 3'b011);
      tick();
      drive(1'b1, 3'b101);
      tick();                                // queued: 010, 011, 101
      check_out("arst.pre", 3'b001, 1'b1, 8'd13);
      check("arst.pre.ready", 8'(op_ready), 8'd1);
      drive(1'b0, 3'b000);
      #2;
      rst = 1'b1;                            // mid-cycle, no clock edge
      #1;
      check_out("arst.now", 3'b000, 1'b0, 8'd0);
      check("arst.err", 8'(err), 8'd0);
      check("arst.ready", 8'(op_ready), 8'd1);
      check("arst.state", 8'(fsm_state), 8'd0);
      stall = 1'b0;
      tick();                                // edge with rst held
      rst = 1'b0;
      drive(1'b1, 3'b101);
      tick();                                // first edge after release: accept
      check_out("arst.acc", 3'b000, 1'b0, 8'd0);
      drive(1'b0, 3'b000);
      tick();
      check_out("arst.first", 3'b101, 1'b1, 8'd1);
      tick();
      check_out("arst.flushed1", 3'b000, 1'b0, 8'd1);
      tick();
      check_out("arst.flushed2", 3'b000, 1'b0, 8'd1);

      // --- Illegal opcode offered while full does not set err -----------------
      stall = 1'b1;
      drive(1'b1, 3'b001);
      tick();
      drive(1'b1, 3'b010);
      tick();
      drive(1'b1, 3'b011);
      tick();
      drive(1'b1, 3'b101);
      tick();
      check("fullill.ready", 8'(op_ready), 8'd0);
      drive(1'b1, 3'b111);
      tick();
      check("fullill.err", 8'(err), 8'd0);
      drive(1'b0, 3'b000);
      stall = 1'b0;
      tick();
      check_out("fullill.d1", 3'b001, 1'b1, 8'd2);
      tick();
      check_out("fullill.d2", 3'b010, 1'b1, 8'd3);
      tick();
      check_out("fullill.d3", 3'b011, 1'b1, 8'd4);
      tick();
      check_out("fullill.d4", 3'b101, 1'b1, 8'd5);
      tick();
      check_out("fullill.idle", 3'b000, 1'b0, 8'd5);

      // --- issued_cnt wraps 255 -> 0 (push and pop on the same edge) ----------
      drive(1'b1, 3'b010);
      for (int i = 0; i < 251; i++) begin
         tick();
      end
      check("wrap.ready", 8'(op_ready), 8'd1);
      check("wrap.cnt250", issued_cnt, 8'd255);
      drive(1'b0, 3'b000);
      tick();
      check_out("wrap.zero", 3'b010, 1'b1, 8'd0);
      tick();
      check_out("wrap.idle", 3'b000, 1'b0, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
